// File: rtl/sa_output_deskew_collector_if.sv
// Bundle between the systolic array bottom row, the deskew collector and the downstream consumer.
// Latency: none (wires only).
// Backpressure: out_valid/out_ready handshake on the aligned result side; the array side cannot stall.
//
// Ports carried:
//   sa_outputs  skewed bottom-row outputs, one element per column
//   in_valid    marks the cycle a vector's row-0 element enters the array
//   out_data    aligned result vector at the FIFO head
//   out_valid   FIFO non-empty
//   out_ready   downstream accepts out_data this cycle
//   fifo_count  vectors currently buffered
//   overflow    sticky drop flag
//   drop_count  saturating count of dropped vectors
interface sa_output_deskew_collector_if #(
    parameter int SA_SIZE         = 8,
    parameter int ACTIVATION_SIZE = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int CNT_WIDTH       = 16
);
    logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0] sa_outputs;
    logic                                    in_valid;
    logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0] out_data;
    logic                                    out_valid;
    logic                                    out_ready;
    logic [$clog2(FIFO_DEPTH+1)-1:0]         fifo_count;
    logic                                    overflow;
    logic [CNT_WIDTH-1:0]                    drop_count;

    // Environment side: drives the array outputs and the downstream ready.
    modport master (
        output sa_outputs, in_valid, out_ready,
        input  out_data, out_valid, fifo_count, overflow, drop_count
    );

    // Collector side.
    modport slave (
        input  sa_outputs, in_valid, out_ready,
        output out_data, out_valid, fifo_count, overflow, drop_count
    );
endinterface

// File: rtl/sa_output_deskew_collector.sv
// Deskews the systolic array bottom-row columns into one aligned vector and buffers it in a FIFO.
// Latency: in_valid at cycle T gives out_valid from cycle T+2*SA_SIZE-1 when the FIFO is empty.
// Backpressure: valid/ready at the output; when full with no pop the incoming vector is dropped and counted.
//
// Ports: clk, resetn (synchronous, active-low), bus (slave modport of sa_output_deskew_collector_if).
module sa_output_deskew_collector #(
    parameter int SA_SIZE         = 8,
    parameter int ACTIVATION_SIZE = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    sa_output_deskew_collector_if.slave  bus
);
    localparam int SR_LEN = 2*SA_SIZE-2;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0] vec_t;

    // ------------------------------------------------------------------
    // Valid tracking. Bit k holds in_valid from k+1 cycles ago, so bit
    // SA_SIZE-2+c marks column c live and the last bit is the push request.
    // Only the last tap is consumed: the column pipelines below land every
    // column on that same cycle, so data seen outside a live tap never
    // reaches the FIFO.
    // ------------------------------------------------------------------
    logic [SR_LEN-1:0] vld_sr;
    logic              push_req;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_sr <= '0;
        end else begin
            vld_sr <= {vld_sr[SR_LEN-2:0], bus.in_valid};
        end
    end

    assign push_req = vld_sr[SR_LEN-1];

    // ------------------------------------------------------------------
    // Deskew: column c is delayed SA_SIZE-1-c cycles; the last column is
    // already aligned and feeds the write port directly. Free-running, no reset.
    // ------------------------------------------------------------------
    logic [ACTIVATION_SIZE-1:0] aligned [SA_SIZE];

    for (genvar c = 0; c < SA_SIZE-1; c++) begin : g_col
        localparam int NSTAGE = SA_SIZE-1-c;
        logic [ACTIVATION_SIZE-1:0] stage [NSTAGE];

        always_ff @(posedge clk) begin
            stage[0] <= bus.sa_outputs[c];
            for (int s = 1; s < NSTAGE; s++) begin
                stage[s] <= stage[s-1];
            end
        end

        assign aligned[c] = stage[NSTAGE-1];
    end

    assign aligned[SA_SIZE-1] = bus.sa_outputs[SA_SIZE-1];

    vec_t wr_vec;

    always_comb begin
        wr_vec = '0;
        for (int c = 0; c < SA_SIZE; c++) begin
            wr_vec[c] = aligned[c];
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    vec_t                 mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 overflow_q;
    logic [CNT_WIDTH-1:0] drop_cnt_q;

    logic full;
    logic empty;
    logic pop;
    logic push;
    logic drop;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign pop   = !empty && bus.out_ready;
    // A pop frees the slot the same cycle, so a full FIFO still accepts.
    assign push  = push_req && (!full || pop);
    assign drop  = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            // Storage is cleared so the head reads zero out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_vec;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_q <= drop_cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.out_data   = mem[rd_ptr];
    assign bus.out_valid  = !empty;
    assign bus.fifo_count = count;
    assign bus.overflow   = overflow_q;
    assign bus.drop_count = drop_cnt_q;

endmodule

// File: tb/tb_sa_output_deskew_collector.sv
// Directed and random stimulus for the deskew collector, checked against a queue-based model.
// Latency: model expects a vector injected at cycle T to be pushed at T+2*SA_SIZE-2.
// Backpressure: out_ready is driven per test to exercise full, drop and simultaneous push/pop.
module tb_sa_output_deskew_collector;
    localparam int S     = 4;
    localparam int A     = 8;
    localparam int D     = 4;
    localparam int CW    = 16;
    localparam int HMAX  = 4096;
    localparam int LAT   = 2*S-2;

    typedef logic [S-1:0][A-1:0] vec_t;

    logic clk;
    logic resetn;

    sa_output_deskew_collector_if #(
        .SA_SIZE(S), .ACTIVATION_SIZE(A), .FIFO_DEPTH(D), .CNT_WIDTH(CW)
    ) bus ();

    sa_output_deskew_collector #(
        .SA_SIZE(S), .ACTIVATION_SIZE(A), .FIFO_DEPTH(D), .CNT_WIDTH(CW)
    ) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: remember every cycle's inputs; a vector injected at T is due
    // at T+LAT, its column c being what the array showed at T+S-1+c. The
    // buffer is a plain queue limited to D entries.
    // ------------------------------------------------------------------
    vec_t   sa_hist [HMAX];
    bit     iv_hist [HMAX];
    vec_t   mq [$];
    bit     m_ovf;
    int     m_drop;
    int     last_rst = -1;
    bit     model_ok = 0;
    bit     done     = 0;

    always @(posedge clk) begin
        bit   pop;
        bit   req;
        int   t;
        vec_t v;
        sa_hist[cyc] = bus.sa_outputs;
        iv_hist[cyc] = bus.in_valid;
        if (!resetn) begin
            mq.delete();
            m_ovf    = 0;
            m_drop   = 0;
            last_rst = cyc;
            model_ok = 1;
        end else begin
            pop = (mq.size() != 0) && bus.out_ready;
            req = 0;
            v   = '0;
            if (cyc >= LAT) begin
                t   = cyc - LAT;
                req = iv_hist[t] && (last_rst < t);
                for (int c = 0; c < S; c++) v[c] = sa_hist[t+S-1+c][c];
            end
            if (pop) void'(mq.pop_front());
            if (req) begin
                if (mq.size() < D) begin
                    mq.push_back(v);
                end else begin
                    m_ovf = 1;
                    if (m_drop < (1 << CW) - 1) m_drop++;
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (model_ok && !done) begin
            chk("out_valid",  64'(bus.out_valid),  64'(mq.size() != 0));
            chk("fifo_count", 64'(bus.fifo_count), 64'(mq.size()));
            chk("overflow",   64'(bus.overflow),   64'(m_ovf));
            chk("drop_count", 64'(bus.drop_count), 64'(m_drop));
            if (mq.size() != 0) chk("out_data", 64'(bus.out_data), 64'(mq[0]));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t vec(input logic [7:0] p, input int k);
        vec_t r;
        for (int c = 0; c < S; c++) r[c] = p + 8'(4*k + c);
        return r;
    endfunction

    // Vectors k=0..nv-1 injected at test cycles 0..nv-1; column c of vector
    // k is p+4k+c, shown at cycle S-1+c+k. Other column slots get filler.
    task automatic drive_cycle(input int m, input int nv, input logic [7:0] p, input bit rnd);
        vec_t v;
        int   k;
        for (int c = 0; c < S; c++) begin
            k = m - (S-1) - c;
            if (k >= 0 && k < nv) v[c] = p + 8'(4*k + c);
            else                  v[c] = rnd ? 8'($urandom) : 8'hFF;
        end
        bus.sa_outputs = v;
        bus.in_valid   = (m >= 0 && m < nv);
    endtask

    task automatic do_reset();
        tick();
        resetn        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        resetn         = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.sa_outputs = '1;

        // Reset state
        tick();
        chk("rst_out_valid",  64'(bus.out_valid),  64'd0);
        chk("rst_fifo_count", 64'(bus.fifo_count), 64'd0);
        chk("rst_overflow",   64'(bus.overflow),   64'd0);
        chk("rst_drop_count", 64'(bus.drop_count), 64'd0);
        chk("rst_out_data",   64'(bus.out_data),   64'd0);
        resetn = 1'b1;

        // 1. Single vector
        for (int m = 0; m <= 12; m++) begin
            tick();
            chk("t1_valid", 64'(bus.out_valid), 64'(m == 7));
            if (m == 7) chk("t1_data", 64'(bus.out_data), 64'h13121110);
            bus.out_ready = 1'b1;
            drive_cycle(m, 1, 8'h10, 0);
        end

        // 2. Back-to-back
        do_reset();
        for (int m = 0; m <= 14; m++) begin
            tick();
            chk("t2_valid", 64'(bus.out_valid), 64'(m >= 7 && m <= 10));
            if (m >= 7 && m <= 10) chk("t2_data", 64'(bus.out_data), 64'(vec(8'h20, m-7)));
            bus.out_ready = 1'b1;
            drive_cycle(m, 4, 8'h20, 0);
        end
        chk("t2_drops", 64'(bus.drop_count), 64'd0);

        // 3. Backpressure fill and drop
        do_reset();
        for (int m = 0; m <= 19; m++) begin
            tick();
            if (m == 11) chk("t3_count_full", 64'(bus.fifo_count), 64'd4);
            if (m == 12) begin
                chk("t3_overflow",   64'(bus.overflow),   64'd1);
                chk("t3_drop_count", 64'(bus.drop_count), 64'd1);
            end
            if (m >= 14 && m <= 17) chk("t3_data", 64'(bus.out_data), 64'(vec(8'h40, m-14)));
            if (m == 18) chk("t3_drained", 64'(bus.out_valid), 64'd0);
            bus.out_ready = (m >= 14);
            drive_cycle(m, 5, 8'h40, 0);
        end

        // 4. Full with simultaneous push/pop
        do_reset();
        for (int m = 0; m <= 18; m++) begin
            tick();
            if (m == 10) begin
                chk("t4_count_pre", 64'(bus.fifo_count), 64'd4);
                chk("t4_head_pre",  64'(bus.out_data),   64'(vec(8'h60, 0)));
            end
            if (m == 11) begin
                chk("t4_count_post", 64'(bus.fifo_count), 64'd4);
                chk("t4_overflow",   64'(bus.overflow),   64'd0);
                chk("t4_drop_count", 64'(bus.drop_count), 64'd0);
            end
            if (m >= 13 && m <= 16) chk("t4_data", 64'(bus.out_data), 64'(vec(8'h60, m-12)));
            if (m == 17) chk("t4_drained", 64'(bus.out_valid), 64'd0);
            bus.out_ready = (m == 10 || m >= 13);
            drive_cycle(m, 5, 8'h60, 0);
        end

        // 5. Reset mid-flight
        do_reset();
        for (int m = 0; m <= 20; m++) begin
            tick();
            chk("t5_valid", 64'(bus.out_valid), 64'd0);
            bus.out_ready = 1'b1;
            resetn        = (m != 4);
            drive_cycle(m, 1, 8'h80, 0);
        end
        chk("t5_overflow",   64'(bus.overflow),   64'd0);
        chk("t5_drop_count", 64'(bus.drop_count), 64'd0);

        // 6. Stall hold with random idle column data
        do_reset();
        for (int m = 0; m <= 14; m++) begin
            tick();
            if (m >= 7 && m <= 12) begin
                chk("t6_hold_valid", 64'(bus.out_valid), 64'd1);
                chk("t6_hold_data",  64'(bus.out_data),  64'(vec(8'hA0, 0)));
            end
            if (m == 13) chk("t6_popped", 64'(bus.out_valid), 64'd0);
            bus.out_ready = (m >= 12);
            drive_cycle(m, 1, 8'hA0, 1);
        end

        // 7. Random traffic with stall windows and one mid-run reset
        do_reset();
        for (int r = 0; r < 300; r++) begin
            tick();
            resetn         = (r != 150);
            bus.in_valid   = 1'($urandom_range(0, 1));
            bus.out_ready  = (r % 50 >= 20) && ($urandom_range(0, 3) != 0);
            for (int c = 0; c < S; c++) bus.sa_outputs[c] = 8'($urandom);
        end

        bus.in_valid = 1'b0;
        repeat (3) tick();
        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_output_deskew_collector.md
Name: sa_output_deskew_collector

Overview:
- Receive side of the fixed-weight systolic array, which advances every cycle with no stall.
- Bottom-row column c of the array produces the result of the vector injected at cycle T during cycle T+SA_SIZE-1+c.
- This block de-skews the columns into one aligned result vector and buffers it in a small FIFO.
- It presents each vector downstream on a valid/ready handshake and flags any vector lost to backpressure.

Parameters:
- SA_SIZE, 8, array dimension; number of output columns.
- ACTIVATION_SIZE, 8, width of each output element.
- FIFO_DEPTH, 4, number of aligned result vectors buffered; power of two, at least 2.
- CNT_WIDTH, 16, width of the dropped-vector counter.

Ports:
- clk  input  1  clock
- resetn  input  1  reset; synchronous, active-low
- sa_outputs  input  [ACTIVATION_SIZE-1:0] x SA_SIZE  skewed bottom-row outputs of the array
- in_valid  input  1  high in cycle T when a vector's row-0 element enters the array
- out_data  output  [ACTIVATION_SIZE-1:0] x SA_SIZE  aligned result vector at FIFO head
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  downstream accepts out_data when high together with out_valid
- fifo_count  output  $clog2(FIFO_DEPTH+1)  vectors currently buffered
- overflow  output  1  sticky; set when a vector is dropped
- drop_count  output  CNT_WIDTH  number of dropped vectors; saturates at all-ones

Behaviour:
- Reset, sampled at posedge with resetn=0:
  - Valid delay line cleared; FIFO emptied.
  - out_valid=0, fifo_count=0, overflow=0, drop_count=0, out_data=0.
  - Deskew data registers need no reset.
- Valid tracking:
  - Shift register of length 2*SA_SIZE-2 carries in_valid.
  - Tap SA_SIZE-1+c marks column c live.
  - The final tap, cycle T+2*SA_SIZE-2, is the FIFO push request.
- Deskew:
  - Column c passes through SA_SIZE-1-c register stages; column SA_SIZE-1 goes directly to the FIFO write port.
  - On push, the FIFO stores sa_outputs[SA_SIZE-1] from that cycle together with column c as sampled in cycle T+SA_SIZE-1+c.
  - Deskew registers shift every cycle, unconditionally.
  - Back-to-back in_valid (one vector per cycle) is fully supported with no bubbles.
- Latency:
  - in_valid at cycle T with an empty FIFO gives out_valid=1 from cycle T+2*SA_SIZE-1.
  - out_data is registered FIFO-head content, never combinational from sa_outputs.
- FIFO:
  - Pop when out_valid and out_ready are both high.
  - Push when the push request is high and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_data and out_valid are held stable while out_valid=1 and out_ready=0.
- Overflow:
  - A push request while full with no pop drops the incoming vector; FIFO contents stay unchanged.
  - overflow goes to 1 the next cycle and stays until reset.
  - drop_count increments by 1, saturating.
- Idle columns: sa_outputs in cycles without a live tap are ignored.
- Reset mid-operation: in-flight and buffered vectors are discarded. Vectors whose in_valid preceded reset never appear.
- out_ready with an empty FIFO has no effect.

Test Plan (SA_SIZE=4, ACTIVATION_SIZE=8, FIFO_DEPTH=4; the bench drives sa_outputs directly):
1. Single vector. in_valid at cycle 0; drive sa_outputs[c]=0x10+c at cycle 3+c and 0xFF at all other cycles; out_ready=1. Expect out_valid=1 only in cycle 7, with out_data={0x10,0x11,0x12,0x13}.
2. Back-to-back. in_valid in cycles 0..3, vector k column c = 0x20+4k+c in cycle 3+c+k. Expect out_valid in cycles 7..10 with vectors k=0..3 in order, and no drops.
3. Backpressure fill. out_ready=0, 5 vectors at cycles 0..4.
   - Expect fifo_count=4 at cycle 11.
   - Expect overflow=1 and drop_count=1 from cycle 12.
   - Expect the 5th vector lost.
   - Raising out_ready then yields vectors 0..3 unchanged.
4. Full with simultaneous push/pop. FIFO full, out_ready=1 in the same cycle as the 5th push. Expect fifo_count stays 4, overflow stays 0, and the 5th vector is delivered last.
5. Reset mid-flight. in_valid at cycle 0, resetn=0 at cycle 4, released at cycle 5. Expect out_valid=0 through cycle 20, and overflow=0, drop_count=0.
6. Stall hold. One vector buffered, out_ready=0 for 5 cycles while sa_outputs toggles randomly. Expect out_data and out_valid constant; the vector pops on the first out_ready=1 cycle.
